// File: rtl/mpu_pkg.sv
// Shared MPU reduction-path definitions.
//  - state_e       : sequencer FSM states
//  - WIDTH_DEF     : default datapath width (matches the wallaceTree width)
//  - LEN_W_DEF     : default beat-count field width
package mpu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/wallace_accum_seq_if.sv
// Bundle of the wallace_accum_seq job-control, operand-stream, tree-drive and
// result-stream signals.
//  slave  : the sequencer side (drives ready/busy/tree inputs/result)
//  master : the environment side (drives start/len/abort/beats/tree sum/out_ready)
interface wallace_accum_seq_if
  import mpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
);
  // job control
  logic             io_start_i;
  logic [LEN_W-1:0] io_len_i;
  logic             io_abort_i;
  logic             io_busy_o;
  // operand beat stream
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_data_0;
  logic [WIDTH-1:0] io_in_data_1;
  logic [WIDTH-1:0] io_in_data_2;
  logic [WIDTH-1:0] io_in_data_3;
  // shared wallaceTree drive / result
  logic [WIDTH-1:0] io_tree_i_0;
  logic [WIDTH-1:0] io_tree_i_1;
  logic [WIDTH-1:0] io_tree_i_2;
  logic [WIDTH-1:0] io_tree_i_3;
  logic [WIDTH-1:0] io_tree_i_4;
  logic [WIDTH-1:0] io_tree_o;
  // result stream
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_data;

  modport slave (
    input  io_start_i, io_len_i, io_abort_i,
    output io_busy_o,
    input  io_in_valid, io_in_data_0, io_in_data_1, io_in_data_2, io_in_data_3,
    output io_in_ready,
    output io_tree_i_0, io_tree_i_1, io_tree_i_2, io_tree_i_3, io_tree_i_4,
    input  io_tree_o,
    output io_out_valid, io_out_data,
    input  io_out_ready
  );

  modport master (
    output io_start_i, io_len_i, io_abort_i,
    input  io_busy_o,
    output io_in_valid, io_in_data_0, io_in_data_1, io_in_data_2, io_in_data_3,
    input  io_in_ready,
    input  io_tree_i_0, io_tree_i_1, io_tree_i_2, io_tree_i_3, io_tree_i_4,
    output io_tree_o,
    input  io_out_valid, io_out_data,
    output io_out_ready
  );
endinterface

// File: rtl/wallace_accum_seq.sv
// Sequencer for a shared 5-input combinational wallaceTree adder.
// Tree inputs 0..3 carry the current operand beat and input 4 carries the
// running accumulator, so one beat is reduced per cycle. After the programmed
// number of beats the sum is held on a valid/ready result port.
//  clock : rising-edge clock
//  reset : asynchronous, active-low
//  io    : wallace_accum_seq_if.slave (control, beat stream, tree drive, result)
module wallace_accum_seq
  import mpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  wallace_accum_seq_if.slave io
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [LEN_W-1:0] rem_q,   rem_d;
  logic             fire;

  // Tree drive is purely combinational in every state; the tree sum is only
  // captured when a beat actually fires.
  assign io.io_tree_i_0 = io.io_in_data_0;
  assign io.io_tree_i_1 = io.io_in_data_1;
  assign io.io_tree_i_2 = io.io_in_data_2;
  assign io.io_tree_i_3 = io.io_in_data_3;
  assign io.io_tree_i_4 = acc_q;

  // Abort masks ready so a beat offered alongside abort is not consumed.
  assign io.io_in_ready  = (state_q == ACC) && !io.io_abort_i;
  assign fire            = io.io_in_ready && io.io_in_valid;
  assign io.io_out_valid = (state_q == DONE);
  assign io.io_out_data  = (state_q == DONE) ? acc_q : '0;
  assign io.io_busy_o    = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    if (io.io_abort_i) begin
      state_d = IDLE;
      acc_d   = '0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (io.io_start_i) begin
            acc_d   = '0;
            rem_d   = io.io_len_i;
            // A zero-length job goes straight to DONE with a zero result.
            state_d = (io.io_len_i != '0) ? ACC : DONE;
          end
        end
        ACC: begin
          if (fire) begin
            acc_d = io.io_tree_o;
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_d = DONE;
          end
        end
        DONE: begin
          // Returning to IDLE here guarantees one IDLE cycle before a new start.
          if (io.io_out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_wallace_accum_seq.sv
// Self-checking bench for wallace_accum_seq. The wallaceTree is modelled as a
// 5-way mod-2^16 sum. Table-driven jobs plus hand-written corner sequences.
module tb_wallace_accum_seq;
  import mpu_pkg::*;

  localparam int WIDTH = 16;
  localparam int LEN_W = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  wallace_accum_seq_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) io ();

  wallace_accum_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  // wallaceTree model
  assign io.io_tree_o = io.io_tree_i_0 + io.io_tree_i_1 + io.io_tree_i_2
                      + io.io_tree_i_3 + io.io_tree_i_4;

  typedef struct packed {
    logic [7:0]             len;
    logic [7:0]             gap;   // idle cycles before each beat
    logic [3:0][3:0][15:0]  d;     // d[beat][word]
    logic [15:0]            exp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_beat(input logic [3:0][15:0] b);
    io.io_in_data_0 = b[0];
    io.io_in_data_1 = b[1];
    io.io_in_data_2 = b[2];
    io.io_in_data_3 = b[3];
  endtask

  // Runs one full job from IDLE; returns with the DUT back in IDLE.
  task automatic run_job(input vec_t v);
    io.io_start_i = 1'b1;
    io.io_len_i   = v.len;
    #1;
    chk("idle_busy", {31'd0, io.io_busy_o}, 32'd0);
    chk("idle_ready", {31'd0, io.io_in_ready}, 32'd0);
    chk("idle_oval", {31'd0, io.io_out_valid}, 32'd0);
    step();
    io.io_start_i = 1'b0;
    if (v.len == 8'd0) begin
      #1;
      chk("len0_ready", {31'd0, io.io_in_ready}, 32'd0);
    end else begin
      for (int b = 0; b < int'(v.len); b++) begin
        for (int g = 0; g < int'(v.gap); g++) begin
          io.io_in_valid = 1'b0;
          #1;
          chk("bubble_ready", {31'd0, io.io_in_ready}, 32'd1);
          chk("bubble_oval", {31'd0, io.io_out_valid}, 32'd0);
          step();
        end
        io.io_in_valid = 1'b1;
        drive_beat(v.d[b]);
        #1;
        chk("acc_ready", {31'd0, io.io_in_ready}, 32'd1);
        step();
      end
      io.io_in_valid = 1'b0;
      #1;
    end
    chk("done_oval", {31'd0, io.io_out_valid}, 32'd1);
    chk("done_data", {16'd0, io.io_out_data}, {16'd0, v.exp});
    chk("done_busy", {31'd0, io.io_busy_o}, 32'd1);
    chk("done_ready", {31'd0, io.io_in_ready}, 32'd0);
    io.io_out_ready = 1'b1;
    step();
    io.io_out_ready = 1'b0;
    #1;
    chk("post_oval", {31'd0, io.io_out_valid}, 32'd0);
    chk("post_data", {16'd0, io.io_out_data}, 32'd0);
    chk("post_busy", {31'd0, io.io_busy_o}, 32'd0);
  endtask

  initial begin
    vec_t v;
    io.io_start_i = 1'b0; io.io_len_i = '0; io.io_abort_i = 1'b0;
    io.io_in_valid = 1'b0; io.io_out_ready = 1'b0;
    drive_beat('0);

    // 1: len=1 {1,2,3,4} -> 10
    vecs[0] = '0; vecs[0].len = 8'd1; vecs[0].d[0] = {16'd4, 16'd3, 16'd2, 16'd1};
    vecs[0].exp = 16'd10;
    // 2: len=3 ones/twos/threes with 2 bubbles -> 24
    vecs[1] = '0; vecs[1].len = 8'd3; vecs[1].gap = 8'd2;
    vecs[1].d[0] = {4{16'd1}}; vecs[1].d[1] = {4{16'd2}}; vecs[1].d[2] = {4{16'd3}};
    vecs[1].exp = 16'h0018;
    // 3: len=2 all 0xFFFF -> 8*0xFFFF mod 2^16 = 0xFFF8
    vecs[2] = '0; vecs[2].len = 8'd2; vecs[2].d[0] = {4{16'hFFFF}}; vecs[2].d[1] = {4{16'hFFFF}};
    vecs[2].exp = 16'hFFF8;
    // 4: len=0 -> 0
    vecs[3] = '0; vecs[3].len = 8'd0; vecs[3].exp = 16'd0;
    // len=4, {1,10,100,1000} each beat -> 4*1111 = 4444 = 0x115C
    vecs[4] = '0; vecs[4].len = 8'd4; vecs[4].gap = 8'd1;
    for (int b = 0; b < 4; b++) vecs[4].d[b] = {16'd1000, 16'd100, 16'd10, 16'd1};
    vecs[4].exp = 16'h115C;

    // reset state
    #12;
    chk("rst_busy", {31'd0, io.io_busy_o}, 32'd0);
    chk("rst_oval", {31'd0, io.io_out_valid}, 32'd0);
    chk("rst_odata", {16'd0, io.io_out_data}, 32'd0);
    chk("rst_ready", {31'd0, io.io_in_ready}, 32'd0);
    chk("rst_tree4", {16'd0, io.io_tree_i_4}, 32'd0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_job(vecs[i]);

    // 5: result held while out_ready low; start in DONE ignored
    v = '0; v.len = 8'd1;
    io.io_start_i = 1'b1; io.io_len_i = 8'd1; step();
    io.io_start_i = 1'b0;
    io.io_in_valid = 1'b1; drive_beat({4{16'd5}}); step();
    io.io_in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      io.io_start_i = (c == 2);
      io.io_len_i   = 8'd3;
      #1;
      chk("hold_oval", {31'd0, io.io_out_valid}, 32'd1);
      chk("hold_data", {16'd0, io.io_out_data}, 32'd20);
      chk("hold_ready", {31'd0, io.io_in_ready}, 32'd0);
      step();
    end
    io.io_start_i = 1'b0;
    io.io_out_ready = 1'b1; step();
    io.io_out_ready = 1'b0; #1;
    chk("hold_exit_busy", {31'd0, io.io_busy_o}, 32'd0);
    step();
    chk("start_ignored_busy", {31'd0, io.io_busy_o}, 32'd0);

    // 6: abort after beat 1 of 4; beat offered with abort is not taken
    io.io_start_i = 1'b1; io.io_len_i = 8'd4; step();
    io.io_start_i = 1'b0;
    io.io_in_valid = 1'b1; drive_beat({4{16'd1}}); step();
    drive_beat({4{16'd9}}); io.io_abort_i = 1'b1; #1;
    chk("abort_ready", {31'd0, io.io_in_ready}, 32'd0);
    step();
    io.io_abort_i = 1'b0; io.io_in_valid = 1'b0; #1;
    chk("abort_busy", {31'd0, io.io_busy_o}, 32'd0);
    chk("abort_oval", {31'd0, io.io_out_valid}, 32'd0);
    chk("abort_acc", {16'd0, io.io_tree_i_4}, 32'd0);
    step();
    chk("abort_oval2", {31'd0, io.io_out_valid}, 32'd0);
    run_job(vecs[0]);   // accumulator must start clean after abort

    // async reset mid-ACC
    io.io_start_i = 1'b1; io.io_len_i = 8'd4; step();
    io.io_start_i = 1'b0;
    io.io_in_valid = 1'b1; drive_beat({4{16'd7}}); step();
    io.io_in_valid = 1'b1; #1;
    chk("pre_rst_acc", {16'd0, io.io_tree_i_4}, 32'd28);
    reset = 1'b0; #1;   // well away from any clock edge
    chk("arst_busy", {31'd0, io.io_busy_o}, 32'd0);
    chk("arst_ready", {31'd0, io.io_in_ready}, 32'd0);
    chk("arst_oval", {31'd0, io.io_out_valid}, 32'd0);
    chk("arst_acc", {16'd0, io.io_tree_i_4}, 32'd0);
    io.io_in_valid = 1'b0;
    #1 reset = 1'b1;
    step();
    run_job(vecs[2]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
